// File: rtl/pic8259_pkg.sv
// ---------------------------------------------------------------------------
// pic8259_pkg
// Definitions shared by the 8259A-style interrupt controller blocks.
//   - CTRL_* : control_state encodings published to the cascade-signal logic
//   - ctrl_state_t : FSM state type built on those encodings
//   - onehot_to_bin : IR one-hot vector to 3-bit level (lowest set bit wins)
// ---------------------------------------------------------------------------
package pic8259_pkg;

  localparam logic [2:0] CTRL_IDLE = 3'd0;
  localparam logic [2:0] CTRL_ACK1 = 3'd1;
  localparam logic [2:0] CTRL_ACK2 = 3'd2;
  localparam logic [2:0] CTRL_ACK3 = 3'd3;
  localparam logic [2:0] CTRL_POLL = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = CTRL_IDLE,
    ST_ACK1 = CTRL_ACK1,
    ST_ACK2 = CTRL_ACK2,
    ST_ACK3 = CTRL_ACK3,
    ST_POLL = CTRL_POLL
  } ctrl_state_t;

  // Scan from the top down so the lowest set bit is the one that sticks;
  // a multi-hot vector therefore reports its lowest IR level.
  function automatic logic [2:0] onehot_to_bin(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        idx = i[2:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// ---------------------------------------------------------------------------
// inta_edge_detect
// Edge detector for the (already synchronised) INTA pin. The previous pin
// sample is held in a register that resets high (INTA idle level), so a pin
// held low through reset does not produce a falling edge.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous, active-high
//   inta_n in  synchronised INTA pin
//   fall   out 1 in the first cycle the pin is seen low
//   rise   out 1 in the first cycle the pin is seen high again
// ---------------------------------------------------------------------------
module inta_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic inta_q_r;

  // Previous INTA sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      inta_q_r <= 1'b1;
    end else begin
      inta_q_r <= inta_n;
    end
  end

  assign fall = inta_q_r & ~inta_n;
  assign rise = ~inta_q_r & inta_n;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_ack_sequencer
// Sequences the 8259A INTA cycle: follows the INTA pulses through
// ACK1/ACK2(/ACK3), latches the acknowledged IR level, and supplies the
// CALL opcode / vector bytes to the data bus buffer.
// Parameter:
//   CALL_OPCODE            byte driven in 8080 ACK1 (master/single only)
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   inta_n                 synchronised INTA pin
//   init_abort             ICW1 write strobe, aborts any sequence
//   mode_8086              1 = 8086 (2 pulses), 0 = 8080/85 (3 pulses)
//   cascade_slave          device acts as cascade slave
//   cascade_output_ack_2_3 grant to drive ACK2/ACK3 bytes
//   highest_request        one-hot winning IR (0 = none)
//   vector_base            ICW2 T7..T3 / A15..A11
//   address_high           ICW2 A15..A8
//   address_low_cfg        ICW1 A7..A5
//   interval_4             ICW1 ADI (1 = 4-byte spacing)
//   auto_eoi_config        ICW4 AEOI
//   poll_command           (POLL_COMMAND_EN only) OCW3 poll strobe
//   read_strobe            (POLL_COMMAND_EN only) data read strobe
//   control_state          IDLE/ACK1/ACK2/ACK3/POLL
//   acknowledge_interrupt  IR latched at ACK1, cleared when sequence ends
//   latch_in_service       1-cycle pulse when an IR is acknowledged
//   end_of_acknowledge     1-cycle pulse after the closing INTA rise
//   auto_eoi_clear         end_of_acknowledge qualified by AEOI
//   data_out               byte to data bus buffer
//   data_out_enable        drive data_out
// Optional feature macro: POLL_COMMAND_EN (poll command support).
// ---------------------------------------------------------------------------
module interrupt_ack_sequencer #(
  parameter logic [7:0] CALL_OPCODE = 8'hCD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inta_n,
  input  logic       init_abort,
  input  logic       mode_8086,
  input  logic       cascade_slave,
  input  logic       cascade_output_ack_2_3,
  input  logic [7:0] highest_request,
  input  logic [4:0] vector_base,
  input  logic [7:0] address_high,
  input  logic [2:0] address_low_cfg,
  input  logic       interval_4,
  input  logic       auto_eoi_config,
`ifdef POLL_COMMAND_EN
  input  logic       poll_command,
  input  logic       read_strobe,
`endif
  output logic [2:0] control_state,
  output logic [7:0] acknowledge_interrupt,
  output logic       latch_in_service,
  output logic       end_of_acknowledge,
  output logic       auto_eoi_clear,
  output logic [7:0] data_out,
  output logic       data_out_enable
);

  import pic8259_pkg::*;

  logic        fall_s;
  logic        rise_s;
  ctrl_state_t state_r, state_s;
  logic        mode_8086_r, mode_8086_s;
  logic [7:0]  ack_r, ack_s;
  logic        lis_r, lis_s;
  logic        eoa_r, eoa_s;
  logic        aeoi_r;
  logic [2:0]  id_s;
  logic [7:0]  byte_s;
  logic        en_s;
  logic        pin_drive_s;

  inta_edge_detect u_edge (
    .clock  (clock),
    .reset  (reset),
    .inta_n (inta_n),
    .fall   (fall_s),
    .rise   (rise_s)
  );

  // Sequencer state and registered pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      mode_8086_r <= 1'b0;
      ack_r       <= 8'h00;
      lis_r       <= 1'b0;
      eoa_r       <= 1'b0;
      aeoi_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      mode_8086_r <= mode_8086_s;
      ack_r       <= ack_s;
      lis_r       <= lis_s;
      eoa_r       <= eoa_s;
      aeoi_r      <= eoa_s & auto_eoi_config;
    end
  end

  // Next-state logic; init_abort overrides any INTA edge in the same cycle.
  always_comb begin
    state_s     = state_r;
    mode_8086_s = mode_8086_r;
    ack_s       = ack_r;
    lis_s       = 1'b0;
    eoa_s       = 1'b0;
    if (init_abort) begin
      state_s = ST_IDLE;
      ack_s   = 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fall_s) begin
            state_s     = ST_ACK1;
            mode_8086_s = mode_8086;
            // No request left at INTA time: acknowledge as spurious IR7.
            ack_s       = (highest_request == 8'h00) ? 8'h80 : highest_request;
            lis_s       = 1'b1;
`ifdef POLL_COMMAND_EN
          end else if (poll_command) begin
            state_s = ST_POLL;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ACK1: begin
          if (fall_s) begin
            state_s = ST_ACK2;
          end else begin
            state_s = ST_ACK1;
          end
        end
        ST_ACK2: begin
          if (mode_8086_r && rise_s) begin
            state_s = ST_IDLE;
            ack_s   = 8'h00;
            eoa_s   = 1'b1;
          end else if (!mode_8086_r && fall_s) begin
            state_s = ST_ACK3;
          end else begin
            state_s = ST_ACK2;
          end
        end
        ST_ACK3: begin
          if (rise_s) begin
            state_s = ST_IDLE;
            ack_s   = 8'h00;
            eoa_s   = 1'b1;
          end else begin
            state_s = ST_ACK3;
          end
        end
`ifdef POLL_COMMAND_EN
        ST_POLL: begin
          // INTA edges are ignored while a poll read is pending.
          if (read_strobe) begin
            state_s = ST_IDLE;
            ack_s   = highest_request;
            lis_s   = 1'b1;
          end else begin
            state_s = ST_POLL;
          end
        end
`endif
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // The first low cycle of a pulse still shows the previous state, so the
  // bus is only driven once the state has caught up with the pulse.
  assign pin_drive_s = ~inta_n & ~fall_s;

  // Data byte selection from registered state and latched IR level.
  always_comb begin
    id_s   = onehot_to_bin(ack_r);
    byte_s = 8'h00;
    en_s   = 1'b0;
    case (state_r)
      ST_ACK1: begin
        if (!mode_8086_r && !cascade_slave) begin
          byte_s = CALL_OPCODE;
          en_s   = pin_drive_s;
        end else begin
          byte_s = 8'h00;
        end
      end
      ST_ACK2: begin
        if (cascade_output_ack_2_3) begin
          en_s = pin_drive_s;
          if (mode_8086_r) begin
            byte_s = {vector_base, id_s};
          end else if (interval_4) begin
            byte_s = {address_low_cfg, id_s, 2'b00};
          end else begin
            byte_s = {address_low_cfg[2:1], id_s, 3'b000};
          end
        end else begin
          byte_s = 8'h00;
        end
      end
      ST_ACK3: begin
        if (!mode_8086_r && cascade_output_ack_2_3) begin
          byte_s = address_high;
          en_s   = pin_drive_s;
        end else begin
          byte_s = 8'h00;
        end
      end
`ifdef POLL_COMMAND_EN
      ST_POLL: begin
        if (read_strobe) begin
          byte_s = {|highest_request, 4'b0000, onehot_to_bin(highest_request)};
          en_s   = 1'b1;
        end else begin
          byte_s = 8'h00;
        end
      end
`endif
      default: begin
        byte_s = 8'h00;
      end
    endcase
  end

  assign control_state         = state_r;
  assign acknowledge_interrupt = ack_r;
  assign latch_in_service      = lis_r;
  assign end_of_acknowledge    = eoa_r;
  assign auto_eoi_clear        = aeoi_r;
  assign data_out              = byte_s;
  assign data_out_enable       = en_s;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interrupt_ack_sequencer
// Directed, table-driven bench for interrupt_ack_sequencer. Each table row
// holds the inputs for one clock cycle and the outputs expected just after
// that edge. Abort/reset corners and the poll command (POLL_COMMAND_EN) are
// exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_interrupt_ack_sequencer;

  typedef struct {
    logic       inta_n;
    logic       mode;
    logic       slave;
    logic       grant;
    logic       adi;
    logic       aeoi_cfg;
    logic [7:0] hr;
    logic [2:0] e_state;
    logic [7:0] e_ack;
    logic       e_lis;
    logic       e_eoa;
    logic       e_aeoi;
    logic [7:0] e_dout;
    logic       e_doe;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       inta_n;
  logic       init_abort;
  logic       mode_8086;
  logic       cascade_slave;
  logic       cascade_output_ack_2_3;
  logic [7:0] highest_request;
  logic [4:0] vector_base;
  logic [7:0] address_high;
  logic [2:0] address_low_cfg;
  logic       interval_4;
  logic       auto_eoi_config;
  logic       poll_command;
  logic       read_strobe;
  logic [2:0] control_state;
  logic [7:0] acknowledge_interrupt;
  logic       latch_in_service;
  logic       end_of_acknowledge;
  logic       auto_eoi_clear;
  logic [7:0] data_out;
  logic       data_out_enable;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  interrupt_ack_sequencer #(.CALL_OPCODE(8'hCD)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .inta_n                 (inta_n),
    .init_abort             (init_abort),
    .mode_8086              (mode_8086),
    .cascade_slave          (cascade_slave),
    .cascade_output_ack_2_3 (cascade_output_ack_2_3),
    .highest_request        (highest_request),
    .vector_base            (vector_base),
    .address_high           (address_high),
    .address_low_cfg        (address_low_cfg),
    .interval_4             (interval_4),
    .auto_eoi_config        (auto_eoi_config),
`ifdef POLL_COMMAND_EN
    .poll_command           (poll_command),
    .read_strobe            (read_strobe),
`endif
    .control_state          (control_state),
    .acknowledge_interrupt  (acknowledge_interrupt),
    .latch_in_service       (latch_in_service),
    .end_of_acknowledge     (end_of_acknowledge),
    .auto_eoi_clear         (auto_eoi_clear),
    .data_out               (data_out),
    .data_out_enable        (data_out_enable)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic add(input logic n, input logic mode, input logic slave, input logic grant,
                     input logic adi, input logic aeoi_cfg, input logic [7:0] hr,
                     input logic [2:0] st, input logic [7:0] ack, input logic lis,
                     input logic eoa, input logic aeoi, input logic [7:0] dout, input logic doe);
    vec_t v;
    v.inta_n = n; v.mode = mode; v.slave = slave; v.grant = grant; v.adi = adi;
    v.aeoi_cfg = aeoi_cfg; v.hr = hr; v.e_state = st; v.e_ack = ack; v.e_lis = lis;
    v.e_eoa = eoa; v.e_aeoi = aeoi; v.e_dout = dout; v.e_doe = doe;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [7:0] ack,
                         input logic lis, input logic eoa, input logic aeoi,
                         input logic [7:0] dout, input logic doe);
    chk({tag, "_state"}, {5'd0, control_state}, {5'd0, st});
    chk({tag, "_ack"},   acknowledge_interrupt, ack);
    chk({tag, "_lis"},   {7'd0, latch_in_service}, {7'd0, lis});
    chk({tag, "_eoa"},   {7'd0, end_of_acknowledge}, {7'd0, eoa});
    chk({tag, "_aeoi"},  {7'd0, auto_eoi_clear}, {7'd0, aeoi});
    chk({tag, "_dout"},  data_out, dout);
    chk({tag, "_doe"},   {7'd0, data_out_enable}, {7'd0, doe});
  endtask

  initial begin
    reset = 1'b1; inta_n = 1'b1; init_abort = 1'b0; mode_8086 = 1'b1;
    cascade_slave = 1'b0; cascade_output_ack_2_3 = 1'b1; highest_request = 8'h00;
    vector_base = 5'h08; address_high = 8'h20; address_low_cfg = 3'b101;
    interval_4 = 1'b1; auto_eoi_config = 1'b1; poll_command = 1'b0; read_strobe = 1'b0;

    //   n  md sl gr adi aeo hr     st    ack    lis eoa aeoi dout   doe
    // 8086 single, IR3, vector_base 08
    add(0, 1, 0, 1, 1, 1, 8'h08, 3'd1, 8'h08, 1, 0, 0, 8'h00, 0);
    add(0, 1, 0, 1, 1, 1, 8'h08, 3'd1, 8'h08, 0, 0, 0, 8'h00, 0);
    add(1, 1, 0, 1, 1, 1, 8'h08, 3'd1, 8'h08, 0, 0, 0, 8'h00, 0);
    add(0, 1, 0, 1, 1, 1, 8'h08, 3'd2, 8'h08, 0, 0, 0, 8'h43, 1);
    add(0, 1, 0, 1, 1, 1, 8'h08, 3'd2, 8'h08, 0, 0, 0, 8'h43, 1);
    add(1, 1, 0, 1, 1, 1, 8'h08, 3'd0, 8'h00, 0, 1, 1, 8'h00, 0);
    add(1, 1, 0, 1, 1, 1, 8'h08, 3'd0, 8'h00, 0, 0, 0, 8'h00, 0);
    // 8080, ADI=1, A7..A5=101, high 20, IR2
    add(0, 0, 0, 1, 1, 1, 8'h04, 3'd1, 8'h04, 1, 0, 0, 8'hCD, 1);
    add(1, 0, 0, 1, 1, 1, 8'h04, 3'd1, 8'h04, 0, 0, 0, 8'hCD, 0);
    add(0, 0, 0, 1, 1, 1, 8'h04, 3'd2, 8'h04, 0, 0, 0, 8'hA8, 1);
    add(1, 0, 0, 1, 1, 1, 8'h04, 3'd2, 8'h04, 0, 0, 0, 8'hA8, 0);
    add(0, 0, 0, 1, 1, 1, 8'h04, 3'd3, 8'h04, 0, 0, 0, 8'h20, 1);
    add(1, 0, 0, 1, 1, 1, 8'h04, 3'd0, 8'h00, 0, 1, 1, 8'h00, 0);
    add(1, 0, 0, 1, 1, 1, 8'h04, 3'd0, 8'h00, 0, 0, 0, 8'h00, 0);
    // spurious 8086; mode pin flips mid-sequence, stored 8086 mode must hold
    add(0, 1, 0, 1, 1, 1, 8'h00, 3'd1, 8'h80, 1, 0, 0, 8'h00, 0);
    add(1, 0, 0, 1, 1, 1, 8'h00, 3'd1, 8'h80, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0, 1, 1, 1, 8'h00, 3'd2, 8'h80, 0, 0, 0, 8'h47, 1);
    add(1, 0, 0, 1, 1, 1, 8'h00, 3'd0, 8'h00, 0, 1, 1, 8'h00, 0);
    // 8080 cascade master without ACK2/ACK3 grant, IR0
    add(0, 0, 0, 0, 1, 1, 8'h01, 3'd1, 8'h01, 1, 0, 0, 8'hCD, 1);
    add(1, 0, 0, 0, 1, 1, 8'h01, 3'd1, 8'h01, 0, 0, 0, 8'hCD, 0);
    add(0, 0, 0, 0, 1, 1, 8'h01, 3'd2, 8'h01, 0, 0, 0, 8'h00, 0);
    add(1, 0, 0, 0, 1, 1, 8'h01, 3'd2, 8'h01, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0, 0, 1, 1, 8'h01, 3'd3, 8'h01, 0, 0, 0, 8'h00, 0);
    add(1, 0, 0, 0, 1, 1, 8'h01, 3'd0, 8'h00, 0, 1, 1, 8'h00, 0);
    add(1, 0, 0, 0, 1, 1, 8'h01, 3'd0, 8'h00, 0, 0, 0, 8'h00, 0);
    // 8080, ADI=0, IR6 -> {10,110,000}
    add(0, 0, 0, 1, 0, 1, 8'h40, 3'd1, 8'h40, 1, 0, 0, 8'hCD, 1);
    add(1, 0, 0, 1, 0, 1, 8'h40, 3'd1, 8'h40, 0, 0, 0, 8'hCD, 0);
    add(0, 0, 0, 1, 0, 1, 8'h40, 3'd2, 8'h40, 0, 0, 0, 8'hB0, 1);
    add(1, 0, 0, 1, 0, 1, 8'h40, 3'd2, 8'h40, 0, 0, 0, 8'hB0, 0);
    add(0, 0, 0, 1, 0, 1, 8'h40, 3'd3, 8'h40, 0, 0, 0, 8'h20, 1);
    add(1, 0, 0, 1, 0, 1, 8'h40, 3'd0, 8'h00, 0, 1, 1, 8'h00, 0);
    // 8086 multi-hot IR4|IR5 (lowest = 4), AEOI off
    add(0, 1, 0, 1, 1, 0, 8'h30, 3'd1, 8'h30, 1, 0, 0, 8'h00, 0);
    add(1, 1, 0, 1, 1, 0, 8'h30, 3'd1, 8'h30, 0, 0, 0, 8'h00, 0);
    add(0, 1, 0, 1, 1, 0, 8'h30, 3'd2, 8'h30, 0, 0, 0, 8'h44, 1);
    add(1, 1, 0, 1, 1, 0, 8'h30, 3'd0, 8'h00, 0, 1, 0, 8'h00, 0);
    // 8080 cascade slave: no CALL byte, IR1 -> {101,001,00}
    add(0, 0, 1, 1, 1, 1, 8'h02, 3'd1, 8'h02, 1, 0, 0, 8'h00, 0);
    add(1, 0, 1, 1, 1, 1, 8'h02, 3'd1, 8'h02, 0, 0, 0, 8'h00, 0);
    add(0, 0, 1, 1, 1, 1, 8'h02, 3'd2, 8'h02, 0, 0, 0, 8'hA4, 1);
    add(1, 0, 1, 1, 1, 1, 8'h02, 3'd2, 8'h02, 0, 0, 0, 8'hA4, 0);
    add(0, 0, 1, 1, 1, 1, 8'h02, 3'd3, 8'h02, 0, 0, 0, 8'h20, 1);
    add(1, 0, 1, 1, 1, 1, 8'h02, 3'd0, 8'h00, 0, 1, 1, 8'h00, 0);

    // Reset state
    step(); step();
    chk_all("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      inta_n = vecs[i].inta_n; mode_8086 = vecs[i].mode; cascade_slave = vecs[i].slave;
      cascade_output_ack_2_3 = vecs[i].grant; interval_4 = vecs[i].adi;
      auto_eoi_config = vecs[i].aeoi_cfg; highest_request = vecs[i].hr;
      step();
      chk_all($sformatf("v%0d", i), vecs[i].e_state, vecs[i].e_ack, vecs[i].e_lis,
              vecs[i].e_eoa, vecs[i].e_aeoi, vecs[i].e_dout, vecs[i].e_doe);
    end

    // Reset in 8080 ACK2 coinciding with an INTA rise: IDLE, no end pulse
    mode_8086 = 1'b0; cascade_slave = 1'b0; cascade_output_ack_2_3 = 1'b1;
    interval_4 = 1'b1; auto_eoi_config = 1'b1; highest_request = 8'h04;
    inta_n = 1'b0; step(); inta_n = 1'b1; step(); inta_n = 1'b0; step();
    chk("rst_pre_state", {5'd0, control_state}, 8'h02);
    reset = 1'b1; inta_n = 1'b1; step();
    chk_all("rst_ack2", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0; step();
    chk_all("rst_after", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // init_abort in 8080 ACK2 coinciding with the fall that would enter ACK3
    inta_n = 1'b0; step(); inta_n = 1'b1; step(); inta_n = 1'b0; step();
    inta_n = 1'b1; step();
    chk("abort_pre_state", {5'd0, control_state}, 8'h02);
    init_abort = 1'b1; inta_n = 1'b0; step();
    chk_all("abort_ack2", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    init_abort = 1'b0; inta_n = 1'b1; step();
    chk_all("abort_after", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

`ifdef POLL_COMMAND_EN
    // Poll with IR5 pending
    highest_request = 8'h20; poll_command = 1'b1; step();
    poll_command = 1'b0;
    chk("poll_state", {5'd0, control_state}, 8'h04);
    inta_n = 1'b0; step();
    chk("poll_inta_ignored", {5'd0, control_state}, 8'h04);
    inta_n = 1'b1; step();
    read_strobe = 1'b1; #1;
    chk("poll_dout", data_out, 8'h85);
    chk("poll_doe", {7'd0, data_out_enable}, 8'h01);
    step();
    read_strobe = 1'b0;
    chk("poll_end_state", {5'd0, control_state}, 8'h00);
    chk("poll_ack", acknowledge_interrupt, 8'h20);
    chk("poll_lis", {7'd0, latch_in_service}, 8'h01);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
